// File: rtl/esp8266_at_sequencer.sv
// ESP8266 AT-command sequencer: streams ROM commands to UART TX,
// parses replies for OK/ERROR, retries, faults, then heartbeats.
module esp8266_at_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int RESP_TIMEOUT = 50000000,
  parameter int MAX_RETRY    = 3,
  parameter int HB_PERIOD    = 250000000,
  parameter int HB_ADDR      = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic [ADDR_W-1:0] Rom_addr,
  input  logic [7:0]        Rom_data,
  output logic [7:0]        Tx_data,
  output logic              Tx_valid,
  input  logic              Tx_ready,
  input  logic [7:0]        Rx_data,
  input  logic              Rx_valid,
  output logic              Busy,
  output logic              Linked,
  output logic              Fault,
  output logic [3:0]        Cmd_idx,
  output logic [3:0]        Retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_SEND,
    S_WAIT_RESP,
    S_HB_WAIT,
    S_FAULT
  } state_e;

  localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0] HB_LAST   = 32'(HB_PERIOD - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] HB_BASE = ADDR_W'(HB_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  // "OK\r\n" and "OR\r\n" (tail of "ERROR\r\n")
  localparam logic [31:0] RSP_OK  = 32'h4F4B0D0A;
  localparam logic [31:0] RSP_ERR = 32'h4F520D0A;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [7:0]        txd_q, txd_d;
  logic              txv_q, txv_d;
  logic              linked_q, linked_d;
  logic              fault_q, fault_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        retry_q, retry_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       shift_nx;
  logic [3:0]        retry_inc;

  // Next-state and datapath updates for the command walker.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_d   = start_q;
    txd_d     = txd_q;
    txv_d     = txv_q;
    linked_d  = linked_q;
    fault_d   = fault_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    shift_nx  = Rx_valid ? {shift_q[23:0], Rx_data} : shift_q;
    retry_inc = retry_q + 4'd1;
    unique case (state_q)
      S_IDLE, S_FAULT: begin
        if (Start) begin
          start_d  = '0;
          addr_d   = '0;
          idx_d    = '0;
          retry_d  = '0;
          fault_d  = 1'b0;
          linked_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT_ROM;
      S_WAIT_ROM: begin
        if (Rom_data == 8'hFF) begin
          linked_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_HB_WAIT;
        end else if (Rom_data == 8'h00) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = S_WAIT_RESP;
        end else begin
          txd_d   = Rom_data;
          txv_d   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (Tx_ready) begin
          txv_d   = 1'b0;
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_FETCH;
        end
      end
      S_WAIT_RESP: begin
        shift_d = shift_nx;
        cnt_d   = cnt_q + 32'd1;
        if (Rx_valid && shift_nx == RSP_OK) begin
          retry_d = '0;
          idx_d   = idx_q + 4'd1;
          addr_d  = addr_q + ADDR_ONE;
          start_d = addr_q + ADDR_ONE;
          state_d = S_FETCH;
        end else if ((Rx_valid && shift_nx == RSP_ERR) ||
                     cnt_q == RESP_LAST) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            fault_d  = 1'b1;
            linked_d = 1'b0;
            state_d  = S_FAULT;
          end else begin
            addr_d  = start_q;
            state_d = S_FETCH;
          end
        end
      end
      S_HB_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == HB_LAST) begin
          addr_d  = HB_BASE;
          start_d = HB_BASE;
          retry_d = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      start_q  <= '0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      linked_q <= 1'b0;
      fault_q  <= 1'b0;
      idx_q    <= '0;
      retry_q  <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
      linked_q <= linked_d;
      fault_q  <= fault_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Rom_addr  = addr_q;
  assign Tx_data   = txd_q;
  assign Tx_valid  = txv_q;
  assign Linked    = linked_q;
  assign Fault     = fault_q;
  assign Cmd_idx   = idx_q;
  assign Retry_cnt = retry_q;
  assign Busy      = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule

// File: tb/tb_esp8266_at_sequencer.sv
// Bench for esp8266_at_sequencer: TX scoreboard fed by a command-level
// model, directed scenarios plus randomized reply/stall sequences.
module tb_esp8266_at_sequencer;

  localparam int AW = 10;
  localparam int RT = 100;
  localparam int MR = 2;
  localparam int HP = 200;
  localparam int HA = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic [AW-1:0] Rom_addr;
  logic [7:0]    Rom_data = 8'h00;
  logic [7:0]    Tx_data;
  logic          Tx_valid;
  logic          Tx_ready = 1'b0;
  logic [7:0]    Rx_data = 8'h00;
  logic          Rx_valid = 1'b0;
  logic          Busy;
  logic          Linked;
  logic          Fault;
  logic [3:0]    Cmd_idx;
  logic [3:0]    Retry_cnt;

  logic [7:0] rom [0:1023];
  logic [7:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int hs_count = 0;
  int hs_base = 0;
  int last_hs_edge = 0;
  int last_rx_edge = 0;
  bit rand_rdy = 1'b0;

  esp8266_at_sequencer #(
    .ADDR_W(AW),
    .RESP_TIMEOUT(RT),
    .MAX_RETRY(MR),
    .HB_PERIOD(HP),
    .HB_ADDR(HA)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Start(Start),
    .Rom_addr(Rom_addr),
    .Rom_data(Rom_data),
    .Tx_data(Tx_data),
    .Tx_valid(Tx_valid),
    .Tx_ready(Tx_ready),
    .Rx_data(Rx_data),
    .Rx_valid(Rx_valid),
    .Busy(Busy),
    .Linked(Linked),
    .Fault(Fault),
    .Cmd_idx(Cmd_idx),
    .Retry_cnt(Retry_cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // synchronous ROM model and optional random TX back-pressure
  always @(posedge Clk) begin
    #1;
    Rom_data = rom[Rom_addr];
    if (rand_rdy) Tx_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // scoreboard monitor: every accepted TX byte is popped and compared
  always @(negedge Clk) begin
    if (!Rst && Tx_valid && Tx_ready) begin
      hs_count++;
      last_hs_edge = cyc_cnt + 1;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL tx_unexpected: got byte %02h, required none",
                 Tx_data);
      end else begin
        chk("tx_byte", {24'h0, Tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    Start = 1'b0;
    Rx_valid = 1'b0;
    cyc(2);
    exp_q.delete();
    Rst = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
  endtask

  // model: a command is the ROM bytes up to its 0x00 terminator
  task automatic expect_cmd(input int a);
    int i;
    i = a;
    while (rom[i] != 8'h00 && rom[i] != 8'hFF) begin
      exp_q.push_back(rom[i]);
      i++;
    end
  endtask

  task automatic drain(input string nm, input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      cyc(1);
      k++;
    end
    chk({nm, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reply(input string s);
    cyc($urandom_range(2, 5));
    for (int i = 0; i < s.len(); i++) begin
      Rx_data = s[i];
      Rx_valid = 1'b1;
      last_rx_edge = cyc_cnt + 1;
      cyc(1);
      Rx_valid = 1'b0;
      if (i < s.len() - 1) cyc($urandom_range(0, 3));
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return Linked;
      1: return Fault;
      2: return Retry_cnt != 4'd0;
      3: return Tx_valid;
      4: return hs_count != hs_base;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input string nm, input int sel,
                           input int bound, output int e);
    int k;
    k = 0;
    while (!cond(sel) && k < bound) begin
      cyc(1);
      k++;
    end
    chk({nm, "_reached"}, {31'h0, cond(sel)}, 1);
    e = cyc_cnt;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rom_addr"}, {22'h0, Rom_addr}, 0);
    chk({nm, "_tx_valid"}, {31'h0, Tx_valid}, 0);
    chk({nm, "_tx_data"}, {24'h0, Tx_data}, 0);
    chk({nm, "_busy"}, {31'h0, Busy}, 0);
    chk({nm, "_linked"}, {31'h0, Linked}, 0);
    chk({nm, "_fault"}, {31'h0, Fault}, 0);
    chk({nm, "_cmd_idx"}, {28'h0, Cmd_idx}, 0);
    chk({nm, "_retry"}, {28'h0, Retry_cnt}, 0);
  endtask

  int e, l, h, bad;
  int ncmd, a, len, m_idx, m_retry, outcome;
  bit faulted, done;
  int cmd_addr [$];

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'hFF;
    rom[0] = 8'h41;
    rom[1] = 8'h54;
    rom[2] = 8'h0D;
    rom[3] = 8'h0A;
    rom[4] = 8'h00;
    rom[16] = 8'h42;
    rom[17] = 8'h00;

    Rst = 1'b1;
    cyc(3);
    check_reset("reset");
    Rst = 1'b0;
    cyc(2);
    chk("idle_busy", {31'h0, Busy}, 0);

    // basic link-up with ready tied high
    Tx_ready = 1'b1;
    expect_cmd(0);
    pulse_start();
    drain("t1", 100);
    reply("OK\r\n");
    wait_cond("t1_linked", 0, 50, e);
    chk("t1_link_latency", e - last_rx_edge, 2);
    chk("t1_cmd_idx", {28'h0, Cmd_idx}, 1);
    chk("t1_busy", {31'h0, Busy}, 1);

    // heartbeat period
    l = e;
    expect_cmd(HA);
    drain("hb1", 400);
    chk("hb1_period", last_hs_edge - l, HP + 3);
    reply("OK\r\n");
    expect_cmd(HA);
    drain("hb2", 400);
    chk("hb2_period", last_hs_edge - last_rx_edge, HP + 5);
    chk("hb2_linked", {31'h0, Linked}, 1);
    chk("hb2_cmd_idx", {28'h0, Cmd_idx}, 2);
    reply("OK\r\n");
    cyc(5);
    chk("hb3_cmd_idx", {28'h0, Cmd_idx}, 3);
    chk("hb3_linked", {31'h0, Linked}, 1);

    // stall on second byte, then ERROR followed by OK
    do_reset();
    Tx_ready = 1'b1;
    hs_base = hs_count;
    expect_cmd(0);
    pulse_start();
    wait_cond("t2_first_byte", 4, 50, e);
    Tx_ready = 1'b0;
    wait_cond("t2_valid", 3, 20, e);
    bad = 0;
    repeat (10) begin
      if (!(Tx_valid && Tx_data == 8'h54)) bad++;
      cyc(1);
    end
    chk("t2_hold_bad_cycles", bad, 0);
    Tx_ready = 1'b1;
    drain("t2", 100);
    reply("ERROR\r\n");
    chk("t3_retry_after_err", {28'h0, Retry_cnt}, 1);
    chk("t3_linked_after_err", {31'h0, Linked}, 0);
    expect_cmd(0);
    drain("t3_resend", 100);
    reply("OK\r\n");
    wait_cond("t3_linked", 0, 50, e);
    chk("t3_retry_cleared", {28'h0, Retry_cnt}, 0);
    chk("t3_cmd_idx", {28'h0, Cmd_idx}, 1);

    // silence: two timeouts lead to FAULT
    do_reset();
    rand_rdy = 1'b1;
    expect_cmd(0);
    pulse_start();
    drain("t4", 200);
    h = last_hs_edge;
    wait_cond("t4_timeout1", 2, 300, e);
    chk("t4_timeout1_len", e - h, RT + 2);
    chk("t4_retry1", {28'h0, Retry_cnt}, 1);
    expect_cmd(0);
    drain("t4_resend", 300);
    h = last_hs_edge;
    wait_cond("t4_fault", 1, 300, e);
    chk("t4_timeout2_len", e - h, RT + 2);
    chk("t4_busy", {31'h0, Busy}, 0);
    chk("t4_linked", {31'h0, Linked}, 0);
    chk("t4_retry2", {28'h0, Retry_cnt}, 2);
    chk("t4_tx_valid", {31'h0, Tx_valid}, 0);
    rand_rdy = 1'b0;
    cyc(1);
    Tx_ready = 1'b0;
    cyc(5);
    chk("t4_fault_hold", {31'h0, Fault}, 1);
    pulse_start();
    chk("t4_restart_fault", {31'h0, Fault}, 0);
    chk("t4_restart_addr", {22'h0, Rom_addr}, 0);
    chk("t4_restart_busy", {31'h0, Busy}, 1);
    chk("t4_restart_retry", {28'h0, Retry_cnt}, 0);

    // reset in the middle of SEND
    wait_cond("t6_send", 3, 20, e);
    chk("t6_tx_data", {24'h0, Tx_data}, 32'h41);
    Rst = 1'b1;
    cyc(1);
    check_reset("t6_rst");
    Rst = 1'b0;
    Tx_ready = 1'b1;
    cyc(5);
    chk("t6_idle_busy", {31'h0, Busy}, 0);
    expect_cmd(0);
    pulse_start();
    drain("t6_restart", 100);
    reply("OK\r\n");
    wait_cond("t6_linked", 0, 50, e);
    chk("t6_cmd_idx", {28'h0, Cmd_idx}, 1);

    // randomized tables, replies and back-pressure
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
      cmd_addr.delete();
      a = 0;
      ncmd = $urandom_range(1, 3);
      for (int c = 0; c < ncmd; c++) begin
        cmd_addr.push_back(a);
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          rom[a] = 8'($urandom_range(1, 254));
          a++;
        end
        rom[a] = 8'h00;
        a++;
      end
      rand_rdy = 1'b1;
      pulse_start();
      m_idx = 0;
      faulted = 1'b0;
      for (int c = 0; c < ncmd && !faulted; c++) begin
        m_retry = 0;
        done = 1'b0;
        while (!done) begin
          expect_cmd(cmd_addr[c]);
          drain("rnd", 400);
          outcome = $urandom_range(0, 3);
          if (outcome < 2) begin
            reply("OK\r\n");
            m_idx++;
            done = 1'b1;
          end else begin
            if (outcome == 2) reply("ERROR\r\n");
            m_retry++;
            if (m_retry == MR) begin
              wait_cond("rnd_fault", 1, 300, e);
              chk("rnd_fault_retry", {28'h0, Retry_cnt}, m_retry);
              chk("rnd_fault_idx", {28'h0, Cmd_idx}, m_idx);
              chk("rnd_fault_busy", {31'h0, Busy}, 0);
              faulted = 1'b1;
              done = 1'b1;
            end else begin
              if (outcome == 3) wait_cond("rnd_timeout", 2, 300, e);
              chk("rnd_retry", {28'h0, Retry_cnt}, m_retry);
            end
          end
        end
      end
      if (!faulted) begin
        wait_cond("rnd_linked", 0, 60, e);
        chk("rnd_cmd_idx", {28'h0, Cmd_idx}, m_idx);
        chk("rnd_retry_zero", {28'h0, Retry_cnt}, 0);
      end
      rand_rdy = 1'b0;
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
